// File: rtl/mc_ctrl_fsm_v2.sv
// Multi-cycle RV32I control FSM: per-phase datapath strobes, fetch handshake,
// bus-timeout and illegal-opcode sticky trap, retired-instruction counter.
module mc_ctrl_fsm_v2 #(
  parameter bit FETCH_HS    = 1'b1,
  parameter int BUS_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             ready,
  input  logic             fetchReady,
  input  logic             stall,
  output logic             PCEn,
  output logic             regFileWe,
  output logic [3:0]       aluControl,
  output logic             aluSrcMuxSel,
  output logic             busWe,
  output logic [2:0]       RFWDSrcMuxSel,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic             transfer,
  output logic             fetchReq,
  output logic             trap,
  output logic [1:0]       trapCause,
  output logic [CNT_W-1:0] instret
);

  localparam int WCNT_W = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_L   = 7'b0000011;

  localparam logic [2:0] WD_ALU  = 3'b000;
  localparam logic [2:0] WD_LOAD = 3'b001;
  localparam logic [2:0] WD_IMM  = 3'b010;
  localparam logic [2:0] WD_AUI  = 3'b011;
  localparam logic [2:0] WD_PC4  = 3'b100;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
  } state_t;

  state_t             r_state, w_next;
  logic [WCNT_W-1:0]  r_wait;
  logic               r_trap;
  logic [1:0]         r_cause;
  logic [CNT_W-1:0]   r_instret;

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic               w_bit30;
  logic               w_bus_state;
  logic               w_timeout;
  logic               w_set_trap;
  logic [1:0]         w_cause;
  logic               w_retire;
  logic               w_bus_entry;
  logic               w_unused_instr;

  assign w_opcode       = instrCode[6:0];
  assign w_funct3       = instrCode[14:12];
  assign w_bit30        = instrCode[30];
  assign w_unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign w_bus_state = (r_state == S_MEM) || (r_state == L_MEM);
  assign w_timeout   = (BUS_TIMEOUT != 0) && w_bus_state && !ready &&
                       (r_wait == WCNT_W'(BUS_TIMEOUT - 1));
  // Every non-FETCH state that lands in FETCH has completed an instruction.
  assign w_retire    = (w_next == FETCH) && (r_state != FETCH);
  assign w_bus_entry = ((w_next == S_MEM) || (w_next == L_MEM)) && (r_state != w_next);

  assign trap      = r_trap;
  assign trapCause = r_cause;
  assign instret   = r_instret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_wait    <= '0;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_trap) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
      if (w_bus_entry)
        r_wait <= '0;
      else if (w_bus_state && !ready && (r_wait != WCNT_W'(BUS_TIMEOUT)))
        r_wait <= r_wait + WCNT_W'(1);
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_trap    = 1'b0;
    w_cause       = CAUSE_NONE;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    busWe         = 1'b0;
    RFWDSrcMuxSel = WD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    transfer      = 1'b0;
    fetchReq      = 1'b0;

    case (r_state)
      FETCH: begin
        fetchReq = !stall;
        if (!stall && ((FETCH_HS == 1'b0) || fetchReady)) begin
          PCEn   = 1'b1;
          w_next = DECODE;
        end
      end
      DECODE: begin
        case (w_opcode)
          OP_R:    w_next = R_EXE;
          OP_I:    w_next = I_EXE;
          OP_B:    w_next = B_EXE;
          OP_LUI:  w_next = LU_EXE;
          OP_AUI:  w_next = AU_EXE;
          OP_JAL:  w_next = J_EXE;
          OP_JLR:  w_next = JL_EXE;
          OP_S:    w_next = S_EXE;
          OP_L:    w_next = L_EXE;
          default: begin
            w_next     = TRAP;
            w_set_trap = 1'b1;
            w_cause    = CAUSE_ILLEGAL;
          end
        endcase
      end
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {w_bit30, w_funct3};
        w_next     = FETCH;
      end
      I_EXE: begin
        // Only shifts (funct3=101) use bit 30; for ADDI etc. it is immediate data.
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        aluControl   = (w_funct3 == 3'b101) ? {w_bit30, w_funct3} : {1'b0, w_funct3};
        w_next       = FETCH;
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {w_bit30, w_funct3};
        w_next     = FETCH;
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = WD_IMM;
        w_next        = FETCH;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = WD_AUI;
        w_next        = FETCH;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        RFWDSrcMuxSel = WD_PC4;
        w_next        = FETCH;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        jalr          = 1'b1;
        RFWDSrcMuxSel = WD_PC4;
        w_next        = FETCH;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        w_next       = S_MEM;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        transfer     = 1'b1;
        // ready takes priority over a timeout landing in the same cycle.
        if (ready) begin
          w_next = FETCH;
        end else if (w_timeout) begin
          w_next     = TRAP;
          w_set_trap = 1'b1;
          w_cause    = CAUSE_TIMEOUT;
        end
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WD_LOAD;
        w_next        = L_MEM;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WD_LOAD;
        transfer      = 1'b1;
        if (ready) begin
          w_next = L_WB;
        end else if (w_timeout) begin
          w_next     = TRAP;
          w_set_trap = 1'b1;
          w_cause    = CAUSE_TIMEOUT;
        end
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WD_LOAD;
        w_next        = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
// Directed bench: a driver pushes hand-computed per-cycle output expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_fsm_v2;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        ready, fetchReady, stall;
  logic        PCEn, regFileWe, aluSrcMuxSel, busWe, branch, jal, jalr;
  logic        transfer, fetchReq, trap;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic [1:0]  trapCause;
  logic [31:0] instret;

  mc_ctrl_fsm_v2 #(.FETCH_HS(1'b1), .BUS_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .ready(ready),
    .fetchReady(fetchReady), .stall(stall), .PCEn(PCEn), .regFileWe(regFileWe),
    .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel), .busWe(busWe),
    .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal), .jalr(jalr),
    .transfer(transfer), .fetchReq(fetchReq), .trap(trap), .trapCause(trapCause),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc, we;
    logic [3:0]  alu;
    logic        src, bwe;
    logic [2:0]  rf;
    logic        br, j, jr, tr, fq, tp;
    logic [1:0]  c;
    logic [31:0] ir;
  } out_t;

  out_t  act;
  out_t  q_exp[$];
  string q_nm[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  assign act = {PCEn, regFileWe, aluControl, aluSrcMuxSel, busWe, RFWDSrcMuxSel,
                branch, jal, jalr, transfer, fetchReq, trap, trapCause, instret};

  function automatic out_t E(input logic pc, we, input logic [3:0] alu,
                             input logic src, bwe, input logic [2:0] rf,
                             input logic br, j, jr, tr, fq, tp,
                             input logic [1:0] c, input logic [31:0] ir);
    return {pc, we, alu, src, bwe, rf, br, j, jr, tr, fq, tp, c, ir};
  endfunction
  function automatic out_t F(input logic pc, fq, input logic [31:0] ir);
    return E(pc, 0, 4'h0, 0, 0, 3'b000, 0, 0, 0, 0, fq, 0, 2'b00, ir);
  endfunction
  function automatic out_t Z(input logic [31:0] ir);
    return E(0, 0, 4'h0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, ir);
  endfunction
  function automatic out_t T(input logic [1:0] c, input logic [31:0] ir);
    return E(0, 0, 4'h0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, c, ir);
  endfunction

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      out_t  e;
      string nm;
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (pc we alu src bwe rf br j jr tr fq tp c ir)",
                 nm, act, e);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [31:0] ins, input logic rdy, frdy, stl,
                     input out_t e, input string nm);
    @(posedge clk);
    #1;
    reset = rst; instrCode = ins; ready = rdy; fetchReady = frdy; stall = stl;
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  // FETCH (handshake ready), DECODE, then the first execute-phase cycle.
  task automatic run(input logic [31:0] ins, input out_t ex, input logic [31:0] ir,
                     input string nm);
    cyc(0, ins, 0, 1, 0, F(1, 1, ir), {nm, "_fetch"});
    cyc(0, ins, 0, 1, 0, Z(ir),       {nm, "_decode"});
    cyc(0, ins, 0, 1, 0, ex,          {nm, "_exe"});
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_ADDI30= 32'h40010093;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_LW    = 32'h0000A083;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  initial begin
    reset = 1'b1; instrCode = '0; ready = 1'b0; fetchReady = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    cyc(1, I_ADD, 0, 0, 0, F(0, 1, 0), "reset_state");

    run(I_ADD,    E(0,1,4'h0,0,0,3'b000,0,0,0,0,0,0,2'b00,0), 0, "add");
    run(I_SUB,    E(0,1,4'h8,0,0,3'b000,0,0,0,0,0,0,2'b00,1), 1, "sub");
    run(I_SRAI,   E(0,1,4'hD,1,0,3'b000,0,0,0,0,0,0,2'b00,2), 2, "srai");
    run(I_ADDI30, E(0,1,4'h0,1,0,3'b000,0,0,0,0,0,0,2'b00,3), 3, "addi_b30");
    run(I_BNE,    E(0,0,4'h1,0,0,3'b000,1,0,0,0,0,0,2'b00,4), 4, "bne");
    run(I_LUI,    E(0,1,4'h0,0,0,3'b010,0,0,0,0,0,0,2'b00,5), 5, "lui");
    run(I_AUIPC,  E(0,1,4'h0,0,0,3'b011,0,0,0,0,0,0,2'b00,6), 6, "auipc");
    run(I_JAL,    E(0,1,4'h0,0,0,3'b100,0,1,0,0,0,0,2'b00,7), 7, "jal");
    run(I_JALR,   E(0,1,4'h0,0,0,3'b100,0,1,1,0,0,0,2'b00,8), 8, "jalr");

    // Load: ready low for three L_MEM cycles, high on the fourth (timeout boundary).
    run(I_LW, E(0,0,4'h0,1,0,3'b001,0,0,0,0,0,0,2'b00,9), 9, "lw");
    for (int k = 0; k < 4; k++)
      cyc(0, I_LW, (k == 3), 1, 0, E(0,0,4'h0,1,0,3'b001,0,0,0,1,0,0,2'b00,9), "lw_mem");
    cyc(0, I_LW, 0, 1, 0, E(0,1,4'h0,1,0,3'b001,0,0,0,0,0,0,2'b00,9), "lw_wb");

    // Store with ready stuck low: four S_MEM cycles, then sticky bus-timeout trap.
    run(I_SW, E(0,0,4'h0,1,0,3'b000,0,0,0,0,0,0,2'b00,10), 10, "sw_to");
    for (int k = 0; k < 4; k++)
      cyc(0, I_SW, 0, 1, 0, E(0,0,4'h0,1,1,3'b000,0,0,0,1,0,0,2'b00,10), "sw_to_mem");
    cyc(0, I_SW, 1, 1, 0, T(2'b10, 10), "sw_to_trap");
    cyc(0, I_SW, 1, 1, 0, T(2'b10, 10), "sw_to_trap_hold");
    cyc(1, I_SW, 0, 1, 0, T(2'b10, 10), "sw_to_trap_rst");

    // Store with ready on the fourth S_MEM cycle: completes, no trap.
    run(I_SW, E(0,0,4'h0,1,0,3'b000,0,0,0,0,0,0,2'b00,0), 0, "sw_ok");
    for (int k = 0; k < 4; k++)
      cyc(0, I_SW, (k == 3), 1, 0, E(0,0,4'h0,1,1,3'b000,0,0,0,1,0,0,2'b00,0), "sw_ok_mem");

    // Reset during S_MEM: next cycle is a clean FETCH (checked by ill_fetch).
    run(I_SW, E(0,0,4'h0,1,0,3'b000,0,0,0,0,0,0,2'b00,1), 1, "sw_rst");
    cyc(1, I_SW, 0, 1, 0, E(0,0,4'h0,1,1,3'b000,0,0,0,1,0,0,2'b00,1), "sw_rst_mem");

    // Illegal opcode: DECODE, then TRAP held for 10 cycles until reset.
    cyc(0, I_ILL, 0, 1, 0, F(1, 1, 0), "ill_fetch");
    cyc(0, I_ILL, 0, 1, 0, Z(0),       "ill_decode");
    for (int k = 0; k < 10; k++)
      cyc(0, I_ILL, 1, 1, 0, T(2'b01, 0), "ill_trap");
    cyc(1, I_ILL, 0, 0, 0, T(2'b01, 0), "ill_trap_rst");

    // Fetch handshake and stall.
    cyc(0, I_ADD, 0, 0, 1, F(0, 0, 0), "hs_stall");
    cyc(0, I_ADD, 0, 0, 0, F(0, 1, 0), "hs_wait");
    cyc(0, I_ADD, 0, 1, 0, F(1, 1, 0), "hs_go");
    cyc(0, I_ADD, 0, 1, 0, Z(0),       "hs_decode");

    repeat (2) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL monitor_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
